// File: rtl/alu_exec_unit_if.sv
// Request/response bundle between the operand mux (master) and alu_exec_unit (slave).
interface alu_exec_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start_i;
  logic [2:0]       ALUCtrl_i;
  logic [WIDTH-1:0] data1_i;
  logic [WIDTH-1:0] data2_i;
  logic             kill_i;
  logic             ready_o;
  logic             valid_o;
  logic [WIDTH-1:0] data_o;
  logic             zero_o;

  modport master (
    output start_i, ALUCtrl_i, data1_i, data2_i, kill_i,
    input  ready_o, valid_o, data_o, zero_o
  );

  modport slave (
    input  start_i, ALUCtrl_i, data1_i, data2_i, kill_i,
    output ready_o, valid_o, data_o, zero_o
  );
endinterface

// File: rtl/alu_exec_unit.sv
// ALU execution unit: single-cycle ops, iterative shift-add MUL, one-cycle valid pulse per result.
// Define ALU_FAST_MUL_EN for a combinational single-cycle MUL (MUL_BUSY state never entered).
module alu_exec_unit #(
  parameter int unsigned WIDTH = 32
) (
  input logic            clk_i,
  input logic            rst_i,
  alu_exec_unit_if.slave bus
);
  localparam int unsigned ShW = $clog2(WIDTH);

  localparam logic [2:0] OpAnd  = 3'b000;
  localparam logic [2:0] OpXor  = 3'b001;
  localparam logic [2:0] OpSll  = 3'b010;
  localparam logic [2:0] OpAdd  = 3'b011;
  localparam logic [2:0] OpSub  = 3'b100;
  localparam logic [2:0] OpMul  = 3'b101;
  localparam logic [2:0] OpAddi = 3'b110;
  localparam logic [2:0] OpSrai = 3'b111;

  typedef enum logic {StIdle, StMulBusy} state_e;

  state_e           r_state, w_state_d;
  logic [WIDTH-1:0] r_a, w_a_d;
  logic [WIDTH-1:0] r_b, w_b_d;
  logic [WIDTH-1:0] r_acc, w_acc_d;
  logic [WIDTH-1:0] r_data, w_data_d;
  logic [ShW-1:0]   r_cnt, w_cnt_d;
  logic             r_valid, w_valid_d;
  logic             r_zero, w_zero_d;

  logic [WIDTH-1:0] w_result;
  logic [WIDTH-1:0] w_mul;
  logic [WIDTH-1:0] w_step;
  logic [ShW-1:0]   w_shamt;

`ifdef ALU_FAST_MUL_EN
  localparam bit FastMul = 1'b1;
  assign w_mul = bus.data1_i * bus.data2_i;
`else
  localparam bit FastMul = 1'b0;
  assign w_mul = '0;
`endif

  assign w_shamt = bus.data2_i[ShW-1:0];
  assign w_step  = r_b[0] ? r_acc + r_a : r_acc;

  always_comb begin
    w_result = '0;
    case (bus.ALUCtrl_i)
      OpAnd:         w_result = bus.data1_i & bus.data2_i;
      OpXor:         w_result = bus.data1_i ^ bus.data2_i;
      OpSll:         w_result = bus.data1_i << w_shamt;
      OpAdd, OpAddi: w_result = bus.data1_i + bus.data2_i;
      OpSub:         w_result = bus.data1_i - bus.data2_i;
      OpMul:         w_result = w_mul;
      OpSrai:        w_result = $unsigned($signed(bus.data1_i) >>> w_shamt);
      default:       w_result = '0;
    endcase
  end

  always_comb begin
    w_state_d = r_state;
    w_a_d     = r_a;
    w_b_d     = r_b;
    w_acc_d   = r_acc;
    w_cnt_d   = r_cnt;
    w_data_d  = r_data;
    w_zero_d  = r_zero;
    w_valid_d = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (bus.start_i) begin
          if (bus.ALUCtrl_i == OpMul && !FastMul) begin
            w_a_d     = bus.data1_i;
            w_b_d     = bus.data2_i;
            w_acc_d   = '0;
            w_cnt_d   = '0;
            w_state_d = StMulBusy;
          end else begin
            w_data_d  = w_result;
            w_zero_d  = (w_result == '0);
            w_valid_d = 1'b1;
          end
        end
      end
      StMulBusy: begin
        // kill wins over completion; a same-cycle start is not looked at here
        if (bus.kill_i) begin
          w_state_d = StIdle;
        end else begin
          w_acc_d = w_step;
          w_a_d   = r_a << 1;
          w_b_d   = r_b >> 1;
          w_cnt_d = r_cnt + ShW'(1);
          if (r_cnt == ShW'(WIDTH - 1)) begin
            w_data_d  = w_step;
            w_zero_d  = (w_step == '0);
            w_valid_d = 1'b1;
            w_state_d = StIdle;
          end
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= StIdle;
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_data  <= '0;
      r_zero  <= 1'b1;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_a     <= w_a_d;
      r_b     <= w_b_d;
      r_acc   <= w_acc_d;
      r_cnt   <= w_cnt_d;
      r_data  <= w_data_d;
      r_zero  <= w_zero_d;
      r_valid <= w_valid_d;
    end
  end

  assign bus.ready_o = (r_state == StIdle);
  assign bus.valid_o = r_valid;
  assign bus.data_o  = r_data;
  assign bus.zero_o  = r_zero;
endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: results predicted from plain arithmetic, checked on valid_o.
// Honours ALU_FAST_MUL_EN when compiled with it (MUL latency 1).
module tb_alu_exec_unit;
  localparam int unsigned WIDTH = 32;
`ifdef ALU_FAST_MUL_EN
  localparam bit Fast = 1'b1;
`else
  localparam bit Fast = 1'b0;
`endif

  localparam logic [2:0] OpAnd  = 3'b000;
  localparam logic [2:0] OpXor  = 3'b001;
  localparam logic [2:0] OpSll  = 3'b010;
  localparam logic [2:0] OpAdd  = 3'b011;
  localparam logic [2:0] OpSub  = 3'b100;
  localparam logic [2:0] OpMul  = 3'b101;
  localparam logic [2:0] OpAddi = 3'b110;
  localparam logic [2:0] OpSrai = 3'b111;

  typedef struct {
    logic [31:0] data;
    int unsigned due;
  } exp_t;

  exp_t        q[$];
  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  int unsigned cyc = 0;
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  logic [31:0] model_data = '0;

  alu_exec_unit_if #(.WIDTH(WIDTH)) bus ();

  alu_exec_unit #(.WIDTH(WIDTH)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string name, input longint unsigned act, input longint unsigned want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  // Reference results from integer arithmetic on 64-bit values, truncated to 32 bits.
  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    longint unsigned ua = a;
    longint unsigned ub = b;
    longint unsigned r;
    longint          s;
    longint          p;
    longint          qt;
    int              sh = int'(b % WIDTH);
    case (op)
      OpAnd:         r = ua & ub;
      OpXor:         r = ua ^ ub;
      OpSll:         r = ua * (64'd1 << sh);
      OpAdd, OpAddi: r = ua + ub;
      OpSub:         r = ua - ub;
      OpMul:         r = ua * ub;
      default: begin
        // arithmetic shift right == floor division by 2^sh
        s  = longint'($signed(a));
        p  = longint'(1) << sh;
        qt = s / p;
        if (s < 0 && (s % p) != 0) qt = qt - 1;
        r  = qt;
      end
    endcase
    return r[31:0];
  endfunction

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit push);
    int unsigned n = 0;
    logic [31:0] res;
    bus.start_i   = 1'b1;
    bus.ALUCtrl_i = op;
    bus.data1_i   = a;
    bus.data2_i   = b;
    while (bus.ready_o !== 1'b1 && n < 100) begin
      @(posedge clk_i);
      #1;
      n++;
    end
    if (n >= 100) check("accept_timeout", 0, 1);
    @(posedge clk_i);
    #1;
    bus.start_i = 1'b0;
    if (push) begin
      res = model(op, a, b);
      model_data = res;
      q.push_back('{data: res, due: cyc + ((op == OpMul && !Fast) ? WIDTH : 0)});
    end
  endtask

  task automatic wait_drain();
    int unsigned n = 0;
    while (q.size() != 0 && n < 200) begin
      @(posedge clk_i);
      #1;
      n++;
    end
    check("drain", q.size(), 0);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_ready"}, bus.ready_o, 1);
    check({tag, "_valid"}, bus.valid_o, 0);
    check({tag, "_data"}, bus.data_o, 0);
    check({tag, "_zero"}, bus.zero_o, 1);
  endtask

  always @(negedge clk_i) begin
    exp_t e;
    if (!rst_i && bus.valid_o === 1'b1) begin
      if (q.size() == 0) begin
        check("unexpected_valid", 1, 0);
      end else begin
        e = q.pop_front();
        check("data", bus.data_o, e.data);
        check("zero", bus.zero_o, (e.data == 0) ? 1 : 0);
        check("latency", cyc, e.due);
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned n;
    logic [2:0]  op;
    bus.start_i   = 1'b0;
    bus.ALUCtrl_i = '0;
    bus.data1_i   = '0;
    bus.data2_i   = '0;
    bus.kill_i    = 1'b0;
    #1 rst_i = 1'b1;
    #1 check_reset_state("reset");
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;

    issue(OpAdd, 32'h7FFF_FFFF, 32'd1, 1'b1);
    issue(OpSub, 32'd5, 32'd5, 1'b1);
    issue(OpSrai, 32'h8000_0000, 32'd4, 1'b1);
    issue(OpSll, 32'd1, 32'h21, 1'b1);

    // MUL: count busy cycles and pulse an ignored start midway
    issue(OpMul, 32'hFFFF_FFFF, 32'd3, 1'b1);
    n = 0;
    while (bus.ready_o === 1'b0 && n < 100) begin
      bus.start_i   = (n == 3);
      bus.ALUCtrl_i = OpAdd;
      bus.data1_i   = 32'd1;
      bus.data2_i   = 32'd1;
      @(posedge clk_i);
      #1;
      n++;
    end
    bus.start_i = 1'b0;
    check("mul_busy_cycles", n, Fast ? 0 : WIDTH);

    // held start during a MUL is taken only once the unit is idle
    issue(OpMul, $urandom, $urandom, 1'b1);
    issue(OpAdd, $urandom, $urandom, 1'b1);

    issue(OpAnd, 32'hF0F0_1234, 32'h0FF0_FFFF, 1'b1);
    issue(OpXor, 32'hAAAA_5555, 32'hFFFF_0000, 1'b1);
    issue(OpAddi, 32'd10, 32'hFFFF_FFF6, 1'b1);
    wait_drain();

    // kill mid-MUL, with a colliding start in the same cycle
    issue(OpMul, 32'd1234, 32'd5678, Fast);
    repeat (4) begin
      @(posedge clk_i);
      #1;
    end
    bus.kill_i = 1'b1;
    if (!Fast) begin
      bus.start_i   = 1'b1;
      bus.ALUCtrl_i = OpAdd;
      bus.data1_i   = 32'd7;
      bus.data2_i   = 32'd7;
    end
    @(posedge clk_i);
    #1;
    bus.kill_i  = 1'b0;
    bus.start_i = 1'b0;
    repeat (40) begin
      @(posedge clk_i);
      #1;
    end
    check("kill_data_hold", bus.data_o, model_data);
    issue(OpAdd, 32'd2, 32'd3, 1'b1);

    // kill while idle must not block an accept
    bus.kill_i = 1'b1;
    issue(OpXor, 32'h1234_5678, 32'h1234_5678, 1'b1);
    bus.kill_i = 1'b0;
    wait_drain();

    // async reset with a MUL in flight (cnt == 10)
    issue(OpMul, 32'd99, 32'd77, Fast);
    repeat (10) begin
      @(posedge clk_i);
      #1;
    end
    #2 rst_i = 1'b1;
    #1 check_reset_state("midreset");
    q.delete();
    model_data = '0;
    @(posedge clk_i);
    #1 check_reset_state("midreset_next");
    @(negedge clk_i);
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;

    for (int i = 0; i < 300; i++) begin
      op = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0:       issue(op, $urandom, 32'($urandom_range(0, 40)), 1'b1);
        1:       issue(op, 32'hFFFF_FFFF - 32'($urandom_range(0, 2)), $urandom, 1'b1);
        default: issue(op, $urandom, $urandom, 1'b1);
      endcase
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk_i);
        #1;
      end
    end
    wait_drain();
    repeat (5) @(posedge clk_i);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
